// File: rtl/bounce_counter_pkg.sv
// Shared definitions for the bounce counter: mode encodings, the effective
// direction type, the load clamp helper and the parameter legality checks
// evaluated at elaboration time by the modules that import this package.
package bounce_counter_pkg;

  // Bounce phase encodings carried on the mode output.
  localparam logic MODE_RISE = 1'b0;
  localparam logic MODE_FALL = 1'b1;

  // Effective direction after the switch input has been applied to mode.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Saturate a value into the closed range [lo, hi].
  function automatic int unsigned clamp(input int unsigned value,
                                        input int unsigned lo,
                                        input int unsigned hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  // Legal parameter set: bounds ordered and representable, step fits between
  // the bounds, and the slow divider has at least two phases.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned min_v,
                                   input int unsigned max_v,
                                   input int unsigned step,
                                   input int unsigned div);
    bit ok;
    ok = 1'b1;
    if (width < 1 || width > 31) begin
      ok = 1'b0;
    end else if (max_v > ((32'd1 << width) - 32'd1)) begin
      ok = 1'b0;
    end
    if (min_v >= max_v) begin
      ok = 1'b0;
    end else if (step < 1 || step > (max_v - min_v)) begin
      ok = 1'b0;
    end
    if (div < 2) ok = 1'b0;
    return ok;
  endfunction

  // The observation square wave splits the period in two equal halves,
  // which needs an even divider.
  function automatic bit div_even_ok(input int unsigned div);
    return (div % 2) == 0;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running slow-tick divider. Counts 0..DIV-1 on every clk_1 edge and
// raises tick for the single cycle in which the count sits at DIV-1.
// Optional macro SLOW_CLK_OUT_EN adds clk_2, a registered ~50% duty square
// wave meant only for observation (it is never used as a clock).
module tick_divider
  import bounce_counter_pkg::*;
#(
  parameter int unsigned DIV = 100
) (
  input  logic clk_1,
  input  logic rst,
  output logic tick
`ifdef SLOW_CLK_OUT_EN
  ,
  output logic clk_2
`endif
);

  localparam int unsigned   CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_tick;

  // Next divider count, wrapping after the last phase.
  always_comb begin
    w_count_next = (r_count == LAST) ? '0 : (r_count + 1'b1);
  end

  // Divider state; tick is registered so it is high exactly while the
  // count register holds DIV-1.
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tick  <= (w_count_next == LAST);
    end
  end

  assign tick = r_tick;

`ifdef SLOW_CLK_OUT_EN
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  generate
    if (!div_even_ok(DIV)) begin : g_bad_div
      $error("tick_divider: DIV must be even when clk_2 is generated");
    end
  endgenerate

  logic r_clk_2;

  // Toggle at the end of each half period so clk_2 has ~50% duty.
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      r_clk_2 <= 1'b0;
    end else if (r_count == HALF || r_count == LAST) begin
      r_clk_2 <= ~r_clk_2;
    end
  end

  assign clk_2 = r_clk_2;
`endif

endmodule

// File: rtl/bounce_counter_gen2.sv
// Up/down bounce counter running entirely on clk_1. The counter walks
// between MIN and MAX in STEP increments, saturating at the bounds, and
// spends one step standing still at each bound while the phase reverses.
// Steps happen every cycle (x=1) or on the slow divider tick (x=0).
// Optional macro SLOW_CLK_OUT_EN exposes the divider's clk_2 square wave.
module bounce_counter_gen2
  import bounce_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MIN   = 0,
  parameter int unsigned MAX   = 15,
  parameter int unsigned STEP  = 1,
  parameter int unsigned DIV   = 100
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             switch,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             mode,
  output logic             tick,
  output logic             bound
`ifdef SLOW_CLK_OUT_EN
  ,
  output logic             clk_2
`endif
);

  // Bounds and step in the one-bit-wider arithmetic domain, so an upward
  // step past MAX is seen as an overshoot rather than a wrap.
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH + 1)'(MIN);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  generate
    if (!params_ok(WIDTH, MIN, MAX, STEP, DIV)) begin : g_bad_params
      $error("bounce_counter_gen2: illegal WIDTH/MIN/MAX/STEP/DIV combination");
    end
  endgenerate

  logic [WIDTH-1:0] r_counter;
  logic             r_mode;
  logic             r_bound;

  logic             w_tick;
  logic             w_step;
  dir_e             w_dir;
  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_up_sum;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk_1 (clk_1),
    .rst   (rst),
    .tick  (w_tick)
`ifdef SLOW_CLK_OUT_EN
    ,
    .clk_2 (clk_2)
`endif
  );

  // Step qualification, effective direction, turnaround detection and the
  // saturated next value for a step in that direction.
  always_comb begin
    w_cnt_x    = {1'b0, r_counter};
    w_up_sum   = w_cnt_x + STEP_X;
    w_step     = en & (x | w_tick);
    w_dir      = ((r_mode == MODE_FALL) ^ switch) ? DIR_DOWN : DIR_UP;
    w_at_bound = 1'b0;
    w_step_val = r_counter;
    if (w_dir == DIR_UP) begin
      w_at_bound = (w_cnt_x >= MAX_X);
      w_step_val = (w_up_sum > MAX_X) ? MAX_N : w_up_sum[WIDTH-1:0];
    end else begin
      w_at_bound = (w_cnt_x <= MIN_X);
      w_step_val = (w_cnt_x < (MIN_X + STEP_X)) ? MIN_N : (r_counter - STEP_N);
    end
    w_load_val = WIDTH'(clamp(32'(load_val), MIN, MAX));
  end

  // Counter, phase and turnaround pulse; load wins over a coincident step
  // and a turnaround step leaves the counter where it is.
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      r_counter <= MIN_N;
      r_mode    <= MODE_RISE;
      r_bound   <= 1'b0;
    end else begin
      r_bound <= 1'b0;
      if (load) begin
        r_counter <= w_load_val;
      end else if (w_step) begin
        if (w_at_bound) begin
          r_mode  <= ~r_mode;
          r_bound <= 1'b1;
        end else begin
          r_counter <= w_step_val;
        end
      end
    end
  end

  assign counter = r_counter;
  assign mode    = r_mode;
  assign bound   = r_bound;
  assign tick    = w_tick;

endmodule

// File: tb/tb_bounce_counter_gen2.sv
// Bench for bounce_counter_gen2. Three instances share one set of inputs:
//   a: WIDTH=4 MIN=0 MAX=15 STEP=1 DIV=4
//   b: WIDTH=4 MIN=0 MAX=14 STEP=4 DIV=4
//   c: WIDTH=5 MIN=3 MAX=15 STEP=2 DIV=6
// Directed scenarios use hand-derived expectations; the random scenario
// compares every instance against an integer reference model each cycle.
// Cycle numbering: "after k edges" counts clock edges with rst high since
// the last reset edge. Optional macro SLOW_CLK_OUT_EN also checks clk_2.
`timescale 1ns/1ps
module tb_bounce_counter_gen2;

  localparam int NI = 3;

  logic       clk_1 = 1'b0;
  logic       rst, en, x, sw, load;
  logic [4:0] load_val;

  logic [3:0] cnt_a, cnt_b;
  logic [4:0] cnt_c;
  logic       mode_a, mode_b, mode_c;
  logic       tick_a, tick_b, tick_c;
  logic       bound_a, bound_b, bound_c;
`ifdef SLOW_CLK_OUT_EN
  logic       clk2_a, clk2_b, clk2_c;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int p_w[NI], p_min[NI], p_max[NI], p_step[NI], p_div[NI];
  int m_n;            // edges with rst high since the last reset edge
  int m_cnt[NI];
  int m_mode[NI];
  int m_bound[NI];

  always #5 clk_1 = ~clk_1;

  bounce_counter_gen2 #(.WIDTH(4), .MIN(0), .MAX(15), .STEP(1), .DIV(4)) dut_a (
    .clk_1(clk_1), .rst(rst), .en(en), .x(x), .switch(sw), .load(load),
    .load_val(load_val[3:0]), .counter(cnt_a), .mode(mode_a), .tick(tick_a),
    .bound(bound_a)
`ifdef SLOW_CLK_OUT_EN
    , .clk_2(clk2_a)
`endif
  );

  bounce_counter_gen2 #(.WIDTH(4), .MIN(0), .MAX(14), .STEP(4), .DIV(4)) dut_b (
    .clk_1(clk_1), .rst(rst), .en(en), .x(x), .switch(sw), .load(load),
    .load_val(load_val[3:0]), .counter(cnt_b), .mode(mode_b), .tick(tick_b),
    .bound(bound_b)
`ifdef SLOW_CLK_OUT_EN
    , .clk_2(clk2_b)
`endif
  );

  bounce_counter_gen2 #(.WIDTH(5), .MIN(3), .MAX(15), .STEP(2), .DIV(6)) dut_c (
    .clk_1(clk_1), .rst(rst), .en(en), .x(x), .switch(sw), .load(load),
    .load_val(load_val), .counter(cnt_c), .mode(mode_c), .tick(tick_c),
    .bound(bound_c)
`ifdef SLOW_CLK_OUT_EN
    , .clk_2(clk2_c)
`endif
  );

  // Slow tick: high while (edges since reset) mod DIV equals DIV-1.
  function automatic int m_tick(input int i);
    return ((m_n % p_div[i]) == p_div[i] - 1) ? 1 : 0;
  endfunction

  // clk_2 toggles once every DIV/2 edges, starting from 0.
  function automatic int m_clk2(input int i);
    return (m_n / (p_div[i] / 2)) % 2;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_update();
    int lv, dn, stp;
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        m_cnt[i]   = p_min[i];
        m_mode[i]  = 0;
        m_bound[i] = 0;
      end else begin
        stp = (en && (x || m_tick(i) == 1)) ? 1 : 0;
        lv  = int'(load_val) & ((1 << p_w[i]) - 1);
        m_bound[i] = 0;
        if (load) begin
          m_cnt[i] = (lv < p_min[i]) ? p_min[i] : ((lv > p_max[i]) ? p_max[i] : lv);
        end else if (stp == 1) begin
          dn = m_mode[i] ^ int'(sw);
          if (dn == 0) begin
            if (m_cnt[i] >= p_max[i]) begin
              m_mode[i] = 1 - m_mode[i]; m_bound[i] = 1;
            end else begin
              m_cnt[i] = (m_cnt[i] + p_step[i] > p_max[i]) ? p_max[i] : m_cnt[i] + p_step[i];
            end
          end else begin
            if (m_cnt[i] <= p_min[i]) begin
              m_mode[i] = 1 - m_mode[i]; m_bound[i] = 1;
            end else begin
              m_cnt[i] = (m_cnt[i] - p_step[i] < p_min[i]) ? p_min[i] : m_cnt[i] - p_step[i];
            end
          end
        end
      end
    end
    if (!rst) m_n = 0;
    else m_n = m_n + 1;
  endtask

  // One clock: model follows the same edge; outputs sampled 1 ns later.
  task automatic cycle();
    model_update();
    @(posedge clk_1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; load = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; x = 1'b1; load = 1'b1; load_val = 5'd9; sw = 1'b0;
    cycle(); cycle();
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); end
    checks++; if (mode_a !== 1'b0) begin errors++; $display("FAIL reset_mode_a: got %b want 0", mode_a); end
    checks++; if (tick_a !== 1'b0) begin errors++; $display("FAIL reset_tick_a: got %b want 0", tick_a); end
    checks++; if (bound_a !== 1'b0) begin errors++; $display("FAIL reset_bound_a: got %b want 0", bound_a); end
    checks++; if (cnt_c !== 5'd3) begin errors++; $display("FAIL reset_cnt_c: got %0d want 3", cnt_c); end
    rst = 1'b1; load = 1'b0;
    repeat (9) cycle();
    checks++; if (cnt_a !== 4'd9) begin errors++; $display("FAIL reset_run9: got %0d want 9", cnt_a); end
    rst = 1'b0;
    cycle();
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_mid_cnt: got %0d want 0", cnt_a); end
    checks++; if (mode_a !== 1'b0) begin errors++; $display("FAIL reset_mid_mode: got %b want 0", mode_a); end
    rst = 1'b1;
  endtask

  task automatic test_fast_bounce();
    do_reset();
    en = 1'b1; x = 1'b1; sw = 1'b0;
    repeat (15) cycle();
    checks++; if (cnt_a !== 4'd15 || mode_a !== 1'b0) begin errors++; $display("FAIL fast_top: got cnt=%0d mode=%b want cnt=15 mode=0", cnt_a, mode_a); end
    cycle();
    checks++; if (cnt_a !== 4'd15 || mode_a !== 1'b1 || bound_a !== 1'b1) begin errors++; $display("FAIL fast_turn_hi: got cnt=%0d mode=%b bound=%b want 15/1/1", cnt_a, mode_a, bound_a); end
    cycle();
    checks++; if (cnt_a !== 4'd14 || bound_a !== 1'b0) begin errors++; $display("FAIL fast_fall: got cnt=%0d bound=%b want 14/0", cnt_a, bound_a); end
    repeat (14) cycle();
    checks++; if (cnt_a !== 4'd0 || mode_a !== 1'b1) begin errors++; $display("FAIL fast_bottom: got cnt=%0d mode=%b want 0/1", cnt_a, mode_a); end
    cycle();
    checks++; if (cnt_a !== 4'd0 || mode_a !== 1'b0 || bound_a !== 1'b1) begin errors++; $display("FAIL fast_turn_lo: got cnt=%0d mode=%b bound=%b want 0/0/1", cnt_a, mode_a, bound_a); end
    cycle();
    checks++; if (cnt_a !== 4'd1) begin errors++; $display("FAIL fast_rise_again: got %0d want 1", cnt_a); end
  endtask

  task automatic test_slow_rate();
    do_reset();
    en = 1'b1; x = 1'b0; sw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 13) en = 1'b0;
      cycle();
      checks++;
      if (tick_a !== 1'((k % 4) == 3)) begin
        errors++; $display("FAIL slow_tick k=%0d: got %b want %b", k, tick_a, (k % 4) == 3);
      end
      checks++;
      if (cnt_a !== 4'((k <= 12) ? k / 4 : 3)) begin
        errors++; $display("FAIL slow_cnt k=%0d: got %0d want %0d", k, cnt_a, (k <= 12) ? k / 4 : 3);
      end
    end
  endtask

  task automatic test_saturating();
    int exp_c[10], exp_m[10], exp_b[10];
    exp_c = '{4, 8, 12, 14, 14, 10, 6, 2, 0, 0};
    exp_m = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    exp_b = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    en = 1'b1; x = 1'b1; sw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (cnt_b !== 4'(exp_c[k]) || mode_b !== 1'(exp_m[k]) || bound_b !== 1'(exp_b[k])) begin
        errors++;
        $display("FAIL sat_step%0d: got cnt=%0d mode=%b bound=%b want %0d/%0d/%0d",
                 k, cnt_b, mode_b, bound_b, exp_c[k], exp_m[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1; x = 1'b1; sw = 1'b0;
    repeat (7) cycle();
    checks++; if (cnt_c !== 5'd15 || mode_c !== 1'b1 || bound_c !== 1'b1) begin errors++; $display("FAIL load_pre: got cnt=%0d mode=%b bound=%b want 15/1/1", cnt_c, mode_c, bound_c); end
    load = 1'b1; load_val = 5'd20; en = 1'b0;
    cycle();
    checks++; if (cnt_c !== 5'd15 || mode_c !== 1'b1 || bound_c !== 1'b0) begin errors++; $display("FAIL load_clamp_hi: got cnt=%0d mode=%b bound=%b want 15/1/0", cnt_c, mode_c, bound_c); end
    checks++; if (cnt_a !== 4'd4) begin errors++; $display("FAIL load_a_trunc: got %0d want 4", cnt_a); end
    load_val = 5'd7; en = 1'b1; x = 1'b1;
    cycle();
    checks++; if (cnt_c !== 5'd7 || mode_c !== 1'b1 || bound_c !== 1'b0) begin errors++; $display("FAIL load_beats_step: got cnt=%0d mode=%b bound=%b want 7/1/0", cnt_c, mode_c, bound_c); end
    checks++; if (cnt_a !== 4'd7) begin errors++; $display("FAIL load_a_beats_step: got %0d want 7", cnt_a); end
    load = 1'b0;
    cycle();
    checks++; if (cnt_c !== 5'd5) begin errors++; $display("FAIL load_then_step: got %0d want 5", cnt_c); end
    load = 1'b1; load_val = 5'd1;
    cycle();
    checks++; if (cnt_c !== 5'd3) begin errors++; $display("FAIL load_clamp_lo: got %0d want 3", cnt_c); end
    load = 1'b0;
  endtask

  task automatic test_invert();
    do_reset();
    en = 1'b1; x = 1'b1; sw = 1'b1;
    cycle();
    checks++; if (cnt_a !== 4'd0 || mode_a !== 1'b1 || bound_a !== 1'b1) begin errors++; $display("FAIL inv_turn: got cnt=%0d mode=%b bound=%b want 0/1/1", cnt_a, mode_a, bound_a); end
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++; if (cnt_a !== 4'(k) || bound_a !== 1'b0) begin errors++; $display("FAIL inv_rise%0d: got cnt=%0d bound=%b want %0d/0", k, cnt_a, bound_a, k); end
    end
    sw = 1'b0;
    cycle();
    checks++; if (cnt_a !== 4'd2) begin errors++; $display("FAIL inv_release: got %0d want 2", cnt_a); end
  endtask

  task automatic test_random();
    logic [31:0] act_cnt[NI], act_mode[NI], act_tick[NI], act_bound[NI];
`ifdef SLOW_CLK_OUT_EN
    logic [31:0] act_clk2[NI];
`endif
    do_reset();
    sw = 1'b0;
    for (int t = 0; t < 600; t++) begin
      rst  = ($urandom_range(0, 99) >= 2);
      en   = ($urandom_range(0, 99) < 80);
      x    = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 99) < 10) sw = ~sw;
      load = ($urandom_range(0, 99) < 5);
      load_val = 5'($urandom);
      cycle();
      act_cnt[0] = 32'(cnt_a);  act_cnt[1] = 32'(cnt_b);  act_cnt[2] = 32'(cnt_c);
      act_mode[0] = 32'(mode_a); act_mode[1] = 32'(mode_b); act_mode[2] = 32'(mode_c);
      act_tick[0] = 32'(tick_a); act_tick[1] = 32'(tick_b); act_tick[2] = 32'(tick_c);
      act_bound[0] = 32'(bound_a); act_bound[1] = 32'(bound_b); act_bound[2] = 32'(bound_c);
`ifdef SLOW_CLK_OUT_EN
      act_clk2[0] = 32'(clk2_a); act_clk2[1] = 32'(clk2_b); act_clk2[2] = 32'(clk2_c);
`endif
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (act_cnt[i] !== 32'(m_cnt[i])) begin errors++; $display("FAIL rand_cnt[%0d] t=%0d: got %0d want %0d", i, t, act_cnt[i], m_cnt[i]); end
        checks++;
        if (act_mode[i] !== 32'(m_mode[i])) begin errors++; $display("FAIL rand_mode[%0d] t=%0d: got %0d want %0d", i, t, act_mode[i], m_mode[i]); end
        checks++;
        if (act_tick[i] !== 32'(m_tick(i))) begin errors++; $display("FAIL rand_tick[%0d] t=%0d: got %0d want %0d", i, t, act_tick[i], m_tick(i)); end
        checks++;
        if (act_bound[i] !== 32'(m_bound[i])) begin errors++; $display("FAIL rand_bound[%0d] t=%0d: got %0d want %0d", i, t, act_bound[i], m_bound[i]); end
`ifdef SLOW_CLK_OUT_EN
        checks++;
        if (act_clk2[i] !== 32'(m_clk2(i))) begin errors++; $display("FAIL rand_clk2[%0d] t=%0d: got %0d want %0d", i, t, act_clk2[i], m_clk2(i)); end
`endif
      end
    end
    rst = 1'b1; load = 1'b0;
  endtask

  initial begin
    p_w    = '{4, 4, 5};
    p_min  = '{0, 0, 3};
    p_max  = '{15, 14, 15};
    p_step = '{1, 4, 2};
    p_div  = '{4, 4, 6};
    m_n = 0;
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = p_min[i]; m_mode[i] = 0; m_bound[i] = 0;
    end
    rst = 1'b0; en = 1'b0; x = 1'b0; sw = 1'b0; load = 1'b0; load_val = '0;

    test_reset();
    test_fast_bounce();
    test_slow_rate();
    test_saturating();
    test_load();
    test_invert();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
